iq_mixer_dump: RTL and testbench

Quadrature downconversion stage of the demodulator, directly downstream of the DDS sin/cos generator. Multiplies each signed ADC sample by the DDS cosine and sine words and integrates the products over a fixed number of samples (integrate-and-dump). Emits one baseband I/Q pair per frame through a valid/ready handshake to the symbol-decision logic.

---
 rtl/iq_mixer_dump_if.sv | 26 ++
 rtl/iq_mixer_dump.sv | 74 +++++++
 tb/tb_iq_mixer_dump.sv | 128 ++++++++++++
 3 files changed

// File: rtl/iq_mixer_dump_if.sv
// iq_mixer_dump_if: sample/LO input and I/Q output handshake bundle for iq_mixer_dump
// Ports: in_valid/in_data/cos/sin (sample + LO words), out_valid/out_ready/i_out/q_out (I/Q pair), overrun (sticky drop flag)
// master: drives samples and out_ready; slave: the mixer side
interface iq_mixer_dump_if #(
  parameter int DATA_W = 12,
  parameter int LO_W = 9,
  parameter int ACC_W = 25
);
  logic in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic signed [LO_W-1:0] cos;
  logic signed [LO_W-1:0] sin;
  logic out_valid;
  logic out_ready;
  logic signed [ACC_W-1:0] i_out;
  logic signed [ACC_W-1:0] q_out;
  logic overrun;
  modport master (
    output in_valid, in_data, cos, sin, out_ready,
    input out_valid, i_out, q_out, overrun
  );
  modport slave (
    input in_valid, in_data, cos, sin, out_ready,
    output out_valid, i_out, q_out, overrun
  );
endinterface

// File: rtl/iq_mixer_dump.sv
// iq_mixer_dump: quadrature mix of ADC samples with DDS cos/sin, integrate-and-dump over DECIM samples
// Ports: clk, rst (sync active-high), bus (slave modport of iq_mixer_dump_if)
module iq_mixer_dump #(
  parameter int DATA_W = 12,
  parameter int LO_W = 9,
  parameter int DECIM = 16,
  parameter int ACC_W = 25
) (
  input logic clk,
  input logic rst,
  iq_mixer_dump_if.slave bus
);
  localparam int PW = DATA_W + LO_W;
  localparam int CW = $clog2(DECIM);
  logic v1;
  logic signed [PW-1:0] p_i, p_q;
  logic [CW-1:0] cnt;
  logic signed [ACC_W-1:0] acc_i, acc_q, res_i, res_q;
  logic dump;
  logic out_valid, overrun;
  logic signed [ACC_W-1:0] i_out, q_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      p_i <= '0;
      p_q <= '0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        p_i <= PW'(bus.in_data) * PW'(bus.cos);
        p_q <= PW'(bus.in_data) * PW'(bus.sin);
      end
    end
  end
  always_comb begin
    dump = v1 && (cnt == CW'(DECIM - 1));
    res_i = acc_i + ACC_W'(p_i);
    res_q = acc_q + ACC_W'(p_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (v1) begin
      cnt <= dump ? '0 : cnt + CW'(1);
      acc_i <= dump ? '0 : res_i;
      acc_q <= dump ? '0 : res_q;
    end
  end
  // A frame completing while the held pair is still unaccepted is dropped, not queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      overrun <= 1'b0;
      i_out <= '0;
      q_out <= '0;
    end else if (dump) begin
      if (!out_valid || bus.out_ready) begin
        out_valid <= 1'b1;
        i_out <= res_i;
        q_out <= res_q;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end
  assign bus.out_valid = out_valid;
  assign bus.overrun = overrun;
  assign bus.i_out = i_out;
  assign bus.q_out = q_out;
endmodule

// File: tb/tb_iq_mixer_dump.sv
// tb_iq_mixer_dump: directed self-checking bench for iq_mixer_dump
module tb_iq_mixer_dump;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  iq_mixer_dump_if #(.DATA_W(12), .LO_W(9), .ACC_W(25)) bus ();
  iq_mixer_dump #(.DATA_W(12), .LO_W(9), .DECIM(16), .ACC_W(25)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic drive(input logic v, input int d, input int c, input int s);
    bus.in_valid = v;
    bus.in_data = 12'(d);
    bus.cos = 9'(c);
    bus.sin = 9'(s);
    tick();
  endtask
  task automatic idle();
    drive(1'b0, 0, 0, 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.cos = '0;
    bus.sin = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_i", bus.i_out, 0);
    chk("rst_q", bus.q_out, 0);
    chk("rst_ovr", bus.overrun, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) drive(1'b1, 100, 255, 0);
    chk("dc_early", bus.out_valid, 0);
    idle();
    chk("dc_valid", bus.out_valid, 1);
    chk("dc_i", bus.i_out, 408000);
    chk("dc_q", bus.q_out, 0);
    idle();
    chk("dc_clear", bus.out_valid, 0);
    chk("dc_hold_i", bus.i_out, 408000);
    for (int k = 0; k < 16; k++) drive(1'b1, -2048, -256, 255);
    idle();
    chk("ext_valid", bus.out_valid, 1);
    chk("ext_i", bus.i_out, 8388608);
    chk("ext_q", bus.q_out, -8355840);
    idle();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 100, 255, 0);
      if (k < 15) idle();
    end
    chk("gap_early", bus.out_valid, 0);
    idle();
    chk("gap_valid", bus.out_valid, 1);
    chk("gap_i", bus.i_out, 408000);
    chk("gap_q", bus.q_out, 0);
    idle();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, 1, 1, 0);
      if (k == 17) begin
        chk("bp_valid1", bus.out_valid, 1);
        chk("bp_i1", bus.i_out, 16);
        chk("bp_ovr0", bus.overrun, 0);
      end
      if (k == 33) chk("bp_ovr1", bus.overrun, 1);
    end
    chk("bp_held_valid", bus.out_valid, 1);
    chk("bp_held_i", bus.i_out, 16);
    bus.out_ready = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    chk("bp_cleared", bus.out_valid, 0);
    chk("bp_sticky", bus.overrun, 1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst2_ovr", bus.overrun, 0);
    for (int k = 1; k <= 32; k++) begin
      if (k <= 16) drive(1'b1, 1, 1, 0);
      else drive(1'b1, 2, 1, 3);
      if (k == 17) chk("sc_f1_i", bus.i_out, 16);
    end
    chk("sc_f1_hold", bus.i_out, 16);
    bus.out_ready = 1'b1;
    idle();
    chk("sc_valid", bus.out_valid, 1);
    chk("sc_f2_i", bus.i_out, 32);
    chk("sc_f2_q", bus.q_out, 96);
    chk("sc_ovr", bus.overrun, 0);
    idle();
    chk("sc_clear", bus.out_valid, 0);
    for (int k = 0; k < 7; k++) drive(1'b1, 50, 10, 0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_i", bus.i_out, 0);
    chk("mr_q", bus.q_out, 0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1, 1, 0);
      if (bus.out_valid !== 1'b0 || bus.i_out !== 0) chk("mr_quiet", bus.i_out, 0);
    end
    chk("mr_early", bus.out_valid, 0);
    idle();
    chk("mr_out_valid", bus.out_valid, 1);
    chk("mr_out_i", bus.i_out, 16);
    chk("mr_out_q", bus.q_out, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
